// File: rtl/seq_div.sv
// Multi-cycle unsigned restoring divider: a / b -> quotient q, remainder r.
// Retires K = N/CC quotient bits per RUN cycle, MSB first, over CC cycles.
module seq_div #(
    parameter int N  = 128,
    parameter int CC = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         dbz
);

    localparam int K  = N / CC;
    localparam int CW = (CC > 1) ? $clog2(CC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // dvd holds the unconsumed dividend bits in its top part and the
    // quotient bits collected so far in its bottom part.
    logic [N-1:0]  dvd;
    logic [N-1:0]  dvs;
    logic [N:0]    rem;
    logic [CW-1:0] cnt;

    logic [N-1:0]  dvd_step;
    logic [N:0]    rem_step;
    logic          accept;
    logic          last;

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (cnt == CW'(CC - 1));
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    // K unrolled restoring steps applied to the current partial remainder.
    always_comb begin
        rem_step = rem;
        dvd_step = dvd;
        for (int k = 0; k < K; k++) begin
            rem_step = {rem_step[N-1:0], dvd_step[N-1]};
            dvd_step = {dvd_step[N-2:0], 1'b0};
            if (rem_step >= {1'b0, dvs}) begin
                rem_step    = rem_step - {1'b0, dvs};
                dvd_step[0] = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a zero divisor skips RUN and reports straight away.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_next = (b == '0) ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture operands, iterate, and publish results only on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd <= '0;
            dvs <= '0;
            rem <= '0;
            cnt <= '0;
            q   <= '0;
            r   <= '0;
            dbz <= 1'b0;
        end else if (accept) begin
            if (b == '0) begin
                q   <= '1;
                r   <= a;
                dbz <= 1'b1;
            end else begin
                dvd <= a;
                dvs <= b;
                rem <= '0;
                cnt <= '0;
            end
        end else if (state == RUN) begin
            dvd <= dvd_step;
            rem <= rem_step;
            cnt <= cnt + CW'(1);
            if (last) begin
                q   <= dvd_step;
                r   <= rem_step[N-1:0];
                dbz <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// Testbench for seq_div: three configurations (8/4, 32/8, 128/1) on one clock.
module tb_seq_div;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic         start8, busy8, done8, dbz8;
    logic [7:0]   a8, b8, q8, r8;
    logic         start32, busy32, done32, dbz32;
    logic [31:0]  a32, b32, q32, r32;
    logic         start128, busy128, done128, dbz128;
    logic [127:0] a128, b128, q128, r128;

    seq_div #(.N(8), .CC(4)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .q(q8), .r(r8), .dbz(dbz8)
    );

    seq_div #(.N(32), .CC(8)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .q(q32), .r(r32), .dbz(dbz32)
    );

    seq_div #(.N(128), .CC(1)) dut128 (
        .clk(clk), .rst(rst), .start(start128), .a(a128), .b(b128),
        .busy(busy128), .done(done128), .q(q128), .r(r128), .dbz(dbz128)
    );

    int checks = 0;
    int errors = 0;

    function automatic int widthOf(input int inst);
        return (inst == 0) ? 8 : ((inst == 1) ? 32 : 128);
    endfunction

    function automatic int ccOf(input int inst);
        return (inst == 0) ? 4 : ((inst == 1) ? 8 : 1);
    endfunction

    function automatic logic [127:0] maskOf(input int inst);
        logic [127:0] m;
        m = '1;
        return m >> (128 - widthOf(inst));
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic setIn(input int inst, input logic s, input logic [127:0] av, input logic [127:0] bv);
        case (inst)
            0: begin start8 = s; a8 = av[7:0]; b8 = bv[7:0]; end
            1: begin start32 = s; a32 = av[31:0]; b32 = bv[31:0]; end
            default: begin start128 = s; a128 = av; b128 = bv; end
        endcase
    endtask

    task automatic sampleOut(input int inst, output logic bsy, output logic dn,
                             output logic [127:0] qo, output logic [127:0] ro, output logic dz);
        case (inst)
            0: begin bsy = busy8; dn = done8; qo = 128'(q8); ro = 128'(r8); dz = dbz8; end
            1: begin bsy = busy32; dn = done32; qo = 128'(q32); ro = 128'(r32); dz = dbz32; end
            default: begin bsy = busy128; dn = done128; qo = q128; ro = r128; dz = dbz128; end
        endcase
    endtask

    // Walk negedges from cycle cyc0 until done is seen or the bound expires.
    task automatic waitDone(input int inst, input int cyc0, output int doneCyc, output int busyCnt,
                            output logic [127:0] qo, output logic [127:0] ro, output logic dzo);
        logic bsy, dn, dz;
        logic [127:0] qs, rs;
        doneCyc = -1;
        busyCnt = 0;
        qo      = 'x;
        ro      = 'x;
        dzo     = 1'bx;
        for (int c = cyc0; c < cyc0 + 40; c++) begin
            sampleOut(inst, bsy, dn, qs, rs, dz);
            if (bsy) busyCnt++;
            if (dn) begin
                doneCyc = c;
                qo      = qs;
                ro      = rs;
                dzo     = dz;
                break;
            end
            @(negedge clk);
        end
    endtask

    // One complete division from IDLE, checked against plain arithmetic.
    task automatic applyStimulus(input int inst, input logic [127:0] av, input logic [127:0] bv,
                                 input string tag);
        logic [127:0] qo, ro, eq, er, qs, rs;
        logic dzo, edz, bsy, dn, dz;
        int dc, bc, cc;
        cc = ccOf(inst);
        if (bv == '0) begin
            eq  = maskOf(inst);
            er  = av;
            edz = 1'b1;
        end else begin
            eq  = av / bv;
            er  = av % bv;
            edz = 1'b0;
        end
        setIn(inst, 1'b1, av, bv);
        @(negedge clk);
        setIn(inst, 1'b0, '0, '0);
        waitDone(inst, 1, dc, bc, qo, ro, dzo);
        checkOutput($sformatf("%s.q", tag), qo, eq);
        checkOutput($sformatf("%s.r", tag), ro, er);
        checkOutput($sformatf("%s.dbz", tag), 128'(dzo), 128'(edz));
        checkOutput($sformatf("%s.done_cycle", tag), 128'(dc), 128'((bv == '0) ? 1 : cc + 1));
        checkOutput($sformatf("%s.busy_len", tag), 128'(bc), 128'((bv == '0) ? 0 : cc));
        if (bv != '0) begin
            checkOutput($sformatf("%s.qb_plus_r", tag), qo * bv + ro, av);
            checkOutput($sformatf("%s.r_lt_b", tag), 128'(ro < bv), 128'(1));
        end
        @(negedge clk);
        sampleOut(inst, bsy, dn, qs, rs, dz);
        checkOutput($sformatf("%s.done_width", tag), 128'(dn), 128'(0));
    endtask

    task automatic runRandom(input int inst, input int count);
        logic [127:0] av, bv, m;
        int w;
        m = maskOf(inst);
        w = widthOf(inst);
        for (int i = 0; i < count; i++) begin
            av = rnd128() & m;
            case ($urandom_range(0, 3))
                0: bv = '0;
                1: bv = 128'($urandom_range(1, 15));
                2: bv = rnd128() & m;
                default: begin
                    av = rnd128() & (m >> (w / 2));
                    bv = (rnd128() & m) | (128'd1 << (w - 1));
                end
            endcase
            applyStimulus(inst, av, bv, $sformatf("rand%0d_%0d", w, i));
        end
    endtask

    initial begin
        logic [127:0] qo, ro, qs, rs;
        logic dzo, bsy, dn, dz;
        int dc, bc;

        setIn(0, 1'b0, '0, '0);
        setIn(1, 1'b0, '0, '0);
        setIn(2, 1'b0, '0, '0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        sampleOut(0, bsy, dn, qs, rs, dz);
        checkOutput("reset.busy", 128'(bsy), 128'(0));
        checkOutput("reset.done", 128'(dn), 128'(0));
        checkOutput("reset.q", qs, 128'(0));
        checkOutput("reset.r", rs, 128'(0));
        checkOutput("reset.dbz", 128'(dz), 128'(0));

        $display("[TB] directed cases, N=8 CC=4");
        applyStimulus(0, 128'd100, 128'd7, "d100_7");
        applyStimulus(0, 128'd255, 128'd0, "d255_0");
        applyStimulus(0, 128'd5, 128'd9, "d5_9");
        applyStimulus(0, 128'd200, 128'd1, "d200_1");
        applyStimulus(0, 128'd255, 128'd255, "d255_255");
        applyStimulus(0, 128'd0, 128'd13, "d0_13");

        // start pulsed mid-run must be ignored
        setIn(0, 1'b1, 128'd100, 128'd7);
        @(negedge clk);
        setIn(0, 1'b0, '0, '0);
        @(negedge clk);
        setIn(0, 1'b1, 128'd1, 128'd1);
        @(negedge clk);
        setIn(0, 1'b0, '0, '0);
        waitDone(0, 3, dc, bc, qo, ro, dzo);
        checkOutput("ignore.done_cycle", 128'(dc), 128'(5));
        checkOutput("ignore.q", qo, 128'd14);
        checkOutput("ignore.r", ro, 128'd2);

        // start in the done cycle is accepted
        setIn(0, 1'b1, 128'd50, 128'd5);
        @(negedge clk);
        setIn(0, 1'b0, '0, '0);
        waitDone(0, 1, dc, bc, qo, ro, dzo);
        checkOutput("back2back.done_cycle", 128'(dc), 128'(5));
        checkOutput("back2back.q", qo, 128'd10);
        checkOutput("back2back.r", ro, 128'd0);
        @(negedge clk);

        // reset in the middle of a run
        setIn(0, 1'b1, 128'd100, 128'd7);
        @(negedge clk);
        setIn(0, 1'b0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sampleOut(0, bsy, dn, qs, rs, dz);
        checkOutput("midrst.busy", 128'(bsy), 128'(0));
        checkOutput("midrst.done", 128'(dn), 128'(0));
        checkOutput("midrst.q", qs, 128'(0));
        checkOutput("midrst.r", rs, 128'(0));
        applyStimulus(0, 128'd100, 128'd7, "after_rst");

        $display("[TB] random cases");
        runRandom(0, 300);
        runRandom(1, 2000);
        runRandom(2, 3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
